// File: rtl/rng_health_fifo.sv
// Decimating health-checked consumer of the 64-bit LFSR entropy source.
// Healthy samples go into a first-word-fall-through FIFO; a failed sample flushes it and raises a sticky alarm.
module rng_health_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SAMPLE_DIV = 64,
  parameter int unsigned REP_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic [63:0]              entropy_i,
  input  logic                     entropy_valid_i,
  output logic [63:0]              data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     alarm_o,
  output logic                     reseed_req_o,
  input  logic                     clear_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned RW = $clog2(REP_LIMIT) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] REP_FAIL = RW'(REP_LIMIT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

  typedef enum logic {
    RUN,
    ALARM
  } state_t;

  state_t state_q, state_d;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [CW-1:0] div_cnt;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;
  logic          have_last;
  logic [63:0]   last_word;
  logic          reseed_q;

  logic qualify, strobe, is_zero, is_rep, rep_fail, fail, pass, push, pop;

  always_comb begin
    qualify  = (state_q == RUN) && enable_i && entropy_valid_i;
    strobe   = qualify && (div_cnt == DIV_LAST);
    is_zero  = (entropy_i == '0);
    is_rep   = have_last && (entropy_i == last_word);
    rep_next = rep_cnt + 1'b1;
    rep_fail = is_rep && (rep_next == REP_FAIL);
    fail     = strobe && (is_zero || rep_fail);
    pass     = strobe && !fail;
    valid_o  = (state_q == RUN) && (count != '0);
    pop      = valid_o && ready_i;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    push     = pass && ((count != FULL) || pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (fail) state_d = ALARM;
      ALARM:   if (clear_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      reseed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      reseed_q <= fail;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entropy_i;
  end

  always_ff @(posedge clk) begin
    if (rst || fail) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      rep_cnt   <= '0;
      have_last <= 1'b0;
      last_word <= '0;
    end else if (state_q == ALARM) begin
      div_cnt <= '0;
      if (clear_i) begin
        rep_cnt   <= '0;
        have_last <= 1'b0;
      end
    end else if (qualify) begin
      div_cnt <= strobe ? '0 : div_cnt + 1'b1;
      if (strobe) begin
        rep_cnt <= is_rep ? rep_next : '0;
        if (pass) begin
          last_word <= entropy_i;
          have_last <= 1'b1;
        end
      end
    end
  end

  assign data_o       = valid_o ? mem[rd_ptr] : '0;
  assign count_o      = count;
  assign alarm_o      = (state_q == ALARM);
  assign reseed_req_o = reseed_q;

endmodule
